// File: rtl/control_unit_pipe.sv
// control_unit_pipe: registered opcode decoder with valid/ready, MULT sequencing and jump flush.
// Define ILLEGAL_TRAP_EN to add a sticky illegal_op flag for opcodes outside the decode table.
module control_unit_pipe #(
   parameter int unsigned OPCODE_W = 5,
   parameter int unsigned ALU_W    = 4,
   parameter int unsigned MULT_LAT = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [OPCODE_W-1:0] Opcode,
   input  logic [1:0]          Flags,
   input  logic                ex_hold,
   output logic                out_valid,
   output logic                stall_req,
   output logic                MuxDireccionPC,
   output logic                MuxSelDirRegB,
   output logic                crtlMuxValA,
   output logic                crtlMuxValB,
   output logic                MuxDirWriteIN,
   output logic                MuxDirMemIN,
   output logic                MuxDatoIN,
   output logic                WriteMemIN,
   output logic                WriteRegIN,
   output logic [ALU_W-1:0]    CodigoALUIN,
   output logic [1:0]          MuxResultIN
`ifdef ILLEGAL_TRAP_EN
   ,
   output logic                illegal_op
`endif
);

   localparam int unsigned CntW = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

   typedef enum logic [1:0] {StRun, StMult, StFlush} state_e;

   typedef struct packed {
      logic             pcSel;
      logic             selDirRegB;
      logic             valA;
      logic             valB;
      logic             dirWrite;
      logic             dirMem;
      logic             dato;
      logic             writeMem;
      logic             writeReg;
      logic [ALU_W-1:0] alu;
      logic [1:0]       result;
   } ctrl_t;

   localparam ctrl_t Bubble = '{dirMem: 1'b1, default: '0};

   state_e          stateQ, stateD;
   logic [CntW-1:0] cntQ, cntD;
   ctrl_t           vecQ, vecD, decVec;
   logic            validQ, validD;
   logic            decValid, decMult, decRedirect, accept;
   logic [4:0]      op5;

   assign op5      = Opcode[4:0];
   assign in_ready = (stateQ != StMult) && !ex_hold;
   assign accept   = in_valid && in_ready;

`ifdef ILLEGAL_TRAP_EN
   logic decIllegal, illegalQ;
`endif

   always_comb begin
      decVec      = Bubble;
      decValid    = 1'b0;
      decMult     = 1'b0;
      decRedirect = 1'b0;
`ifdef ILLEGAL_TRAP_EN
      decIllegal  = 1'b0;
`endif
      if (|(Opcode >> 5)) begin
`ifdef ILLEGAL_TRAP_EN
         decIllegal = 1'b1;
`endif
      end else begin
         case (op5)
            5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101,
            5'b00110, 5'b00111, 5'b01000, 5'b01001, 5'b10000: begin
               decValid        = 1'b1;
               decVec.result   = 2'b10;
               decVec.dato     = 1'b1;
               decVec.writeReg = 1'b1;
               decVec.valB     = (op5 == 5'b00001) || (op5 == 5'b00011) || (op5 == 5'b00101);
               case (op5)
                  5'b00000, 5'b00001: decVec.alu = ALU_W'(4'b0011);
                  5'b00010, 5'b00011: decVec.alu = ALU_W'(4'b0100);
                  5'b00100, 5'b00101: decVec.alu = ALU_W'(4'b0101);
                  5'b00110:           decVec.alu = ALU_W'(4'b0000);
                  5'b00111:           decVec.alu = ALU_W'(4'b0001);
                  5'b01000:           decVec.alu = ALU_W'(4'b0110);
                  5'b01001:           decVec.alu = ALU_W'(4'b0010);
                  default:            decVec.alu = ALU_W'(4'b0111);
               endcase
            end
            5'b01010, 5'b01011: begin
               decValid        = 1'b1;
               decVec.result   = 2'b11;
               decVec.dirMem   = 1'b0;
               decVec.writeReg = 1'b1;
               decVec.valA     = op5[0];
            end
            5'b01100, 5'b01101: begin
               decValid          = 1'b1;
               decVec.selDirRegB = 1'b1;
               decVec.writeMem   = 1'b1;
               decVec.valA       = op5[0];
            end
            5'b01110, 5'b01111: begin
               decValid        = 1'b1;
               decVec.result   = 2'b00;
               decVec.dato     = 1'b1;
               decVec.writeReg = 1'b1;
               decVec.valA     = op5[0];
            end
            5'b10011: begin
               decValid      = 1'b1;
               decVec.pcSel  = 1'b1;
               decVec.dirMem = 1'b0;
               decRedirect   = 1'b1;
            end
            5'b10100, 5'b10101: begin
               // Not-taken branches still count as valid ops, just with a bubble vector.
               decValid     = 1'b1;
               decRedirect  = (op5 == 5'b10100) ? Flags[0] : (Flags != 2'b01);
               decVec.pcSel = decRedirect;
            end
            5'b10110: begin
               decValid        = 1'b1;
               decMult         = 1'b1;
               decVec.alu      = ALU_W'(4'b1000);
               decVec.result   = 2'b01;
               decVec.dirWrite = 1'b1;
               decVec.dato     = 1'b1;
               decVec.writeReg = 1'b1;
            end
            5'b10111, 5'b10001, 5'b10010: ;
            default: begin
`ifdef ILLEGAL_TRAP_EN
               decIllegal = 1'b1;
`endif
            end
         endcase
      end
   end

   always_comb begin
      stateD = stateQ;
      cntD   = cntQ;
      vecD   = vecQ;
      validD = validQ;
      if (!ex_hold) begin
         case (stateQ)
            StRun: begin
               if (accept) begin
                  vecD   = decVec;
                  validD = decValid;
                  if (decMult && (MULT_LAT > 1)) begin
                     vecD.writeReg = 1'b0;
                     cntD          = CntW'(MULT_LAT - 1);
                     stateD        = StMult;
                  end else if (decRedirect) begin
                     stateD = StFlush;
                  end
               end else begin
                  vecD   = Bubble;
                  validD = 1'b0;
               end
            end
            StMult: begin
               if (cntQ == CntW'(1)) begin
                  vecD.writeReg = 1'b1;
                  cntD          = '0;
                  stateD        = StRun;
               end else begin
                  cntD = cntQ - CntW'(1);
               end
            end
            default: begin
               vecD   = Bubble;
               validD = 1'b0;
               stateD = StRun;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stateQ <= StRun;
         cntQ   <= '0;
         vecQ   <= Bubble;
         validQ <= 1'b0;
      end else begin
         stateQ <= stateD;
         cntQ   <= cntD;
         vecQ   <= vecD;
         validQ <= validD;
      end
   end

`ifdef ILLEGAL_TRAP_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         illegalQ <= 1'b0;
      end else if (accept && (stateQ == StRun) && decIllegal) begin
         illegalQ <= 1'b1;
      end
   end

   assign illegal_op = illegalQ;
`endif

   assign out_valid      = validQ;
   assign stall_req      = (stateQ == StMult);
   assign MuxDireccionPC = vecQ.pcSel;
   assign MuxSelDirRegB  = vecQ.selDirRegB;
   assign crtlMuxValA    = vecQ.valA;
   assign crtlMuxValB    = vecQ.valB;
   assign MuxDirWriteIN  = vecQ.dirWrite;
   assign MuxDirMemIN    = vecQ.dirMem;
   assign MuxDatoIN      = vecQ.dato;
   assign WriteMemIN     = vecQ.writeMem;
   assign WriteRegIN     = vecQ.writeReg;
   assign CodigoALUIN    = vecQ.alu;
   assign MuxResultIN    = vecQ.result;

endmodule
